// File: rtl/car_motion_if.sv
// Signal bundle between the direction/door controller and the car motion model.
// The controller side drives calls, direction and door; the car side returns its position.
interface car_motion_if;
  logic [7:0] sw;
  logic       dir;
  logic       door;
  logic [2:0] floor;
  logic       moving;
  logic       travel_dir;
  logic       arrived;

  modport master (
    output sw, dir, door,
    input  floor, moving, travel_dir, arrived
  );

  modport slave (
    input  sw, dir, door,
    output floor, moving, travel_dir, arrived
  );
endinterface

// File: rtl/car_motion.sv
// Elevator car motion model: departs from IDLE toward pending calls, advances one floor
// every TRAVEL_CYCLES clocks, and stops at a called floor or when nothing lies further on.
module car_motion #(
  parameter int TRAVEL_CYCLES = 100_000_000,
  parameter int CNT_W         = 27
) (
  input  logic         clk,
  input  logic         rst,
  car_motion_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAVEL = 2'd1,
    ARRIVE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       floor_q, floor_d;
  logic             moving_q, moving_d;
  logic             tdir_q, tdir_d;
  logic             arrived_q, arrived_d;

  logic [2:0]       nf;
  logic             req_up, req_down, req_beyond;

  // nf is the floor reached at the end of the current leg; only meaningful in TRAVEL.
  always_comb begin
    req_up     = 1'b0;
    req_down   = 1'b0;
    req_beyond = 1'b0;
    nf         = tdir_q ? (floor_q + 3'd1) : (floor_q - 3'd1);
    for (int i = 0; i < 8; i++) begin
      if (bus.sw[i] && (3'(i) > floor_q)) req_up = 1'b1;
      if (bus.sw[i] && (3'(i) < floor_q)) req_down = 1'b1;
      if (bus.sw[i] && (tdir_q ? (3'(i) > nf) : (3'(i) < nf))) req_beyond = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    floor_d   = floor_q;
    moving_d  = moving_q;
    tdir_d    = tdir_q;
    arrived_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.door && (bus.dir ? req_up : req_down)) begin
          tdir_d   = bus.dir;
          cnt_d    = '0;
          moving_d = 1'b1;
          state_d  = TRAVEL;
        end
      end
      TRAVEL: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          floor_d = nf;
          if (bus.sw[nf] || !req_beyond) begin
            moving_d  = 1'b0;
            arrived_d = 1'b1;
            state_d   = ARRIVE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARRIVE: begin
        moving_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        moving_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      floor_q   <= 3'd0;
      moving_q  <= 1'b0;
      tdir_q    <= 1'b1;
      arrived_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      floor_q   <= floor_d;
      moving_q  <= moving_d;
      tdir_q    <= tdir_d;
      arrived_q <= arrived_d;
    end
  end

  assign bus.floor      = floor_q;
  assign bus.moving     = moving_q;
  assign bus.travel_dir = tdir_q;
  assign bus.arrived    = arrived_q;

endmodule

// File: tb/tb_car_motion.sv
// Bench for car_motion with TRAVEL_CYCLES=4: directed trips plus a randomized run
// compared every cycle against a floor/time-remaining model of the car.
module tb_car_motion;
  localparam int TC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  car_motion_if bus ();

  car_motion #(.TRAVEL_CYCLES(TC), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: car position, whether it is travelling, clocks left in the current leg.
  int   m_floor;
  int   m_left;
  logic m_moving, m_dir, m_arr;

  function automatic bit calls_above(logic [7:0] s, int f);
    return (s >> (f + 1)) != 8'd0;
  endfunction

  function automatic bit calls_below(logic [7:0] s, int f);
    return (s & 8'((1 << f) - 1)) != 8'd0;
  endfunction

  always @(posedge clk) begin : model
    if (rst) begin
      m_floor <= 0; m_moving <= 1'b0; m_dir <= 1'b1; m_arr <= 1'b0; m_left <= 0;
    end else if (m_arr) begin
      m_arr <= 1'b0;
    end else if (m_moving) begin
      if (m_left == 1) begin
        m_floor <= m_dir ? m_floor + 1 : m_floor - 1;
        if (bus.sw[m_dir ? m_floor + 1 : m_floor - 1] ||
            !(m_dir ? calls_above(bus.sw, m_floor + 1) : calls_below(bus.sw, m_floor - 1))) begin
          m_moving <= 1'b0;
          m_arr    <= 1'b1;
        end else begin
          m_left <= TC;
        end
      end else begin
        m_left <= m_left - 1;
      end
    end else if (!bus.door && (bus.dir ? calls_above(bus.sw, m_floor)
                                       : calls_below(bus.sw, m_floor))) begin
      m_dir    <= bus.dir;
      m_moving <= 1'b1;
      m_left   <= TC;
    end
  end

  // Advances up to limit clocks until an arrived pulse is seen at a falling edge.
  task automatic run_until_arrived(input int limit, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (!ok && cycles < limit) begin
      @(negedge clk);
      cycles++;
      if (bus.arrived === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.sw = 8'h00; bus.dir = 1'b1; bus.door = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.floor !== 3'd0) begin errors++; $display("FAIL reset_floor got=%0d exp=0", bus.floor); end
    checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL reset_moving got=%b exp=0", bus.moving); end
    checks++; if (bus.travel_dir !== 1'b1) begin errors++; $display("FAIL reset_tdir got=%b exp=1", bus.travel_dir); end
    checks++; if (bus.arrived !== 1'b0) begin errors++; $display("FAIL reset_arrived got=%b exp=0", bus.arrived); end
  endtask

  task automatic test_up_trip();
    int pulses = 0;
    bus.door = 1'b0; bus.dir = 1'b1; bus.sw = 8'h08;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (bus.arrived === 1'b1) pulses++;
      if (k == 1) begin
        checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL up_depart moving got=%b exp=1", bus.moving); end
      end
      if (k == 4) begin
        checks++; if (bus.floor !== 3'd0) begin errors++; $display("FAIL up_early floor got=%0d exp=0", bus.floor); end
      end
      if (k == 5) begin
        checks++; if (bus.floor !== 3'd1) begin errors++; $display("FAIL up_floor1 got=%0d exp=1", bus.floor); end
      end
      if (k == 9) begin
        checks++; if (bus.floor !== 3'd2) begin errors++; $display("FAIL up_floor2 got=%0d exp=2", bus.floor); end
      end
      if (k == 13) begin
        checks++; if (bus.floor !== 3'd3) begin errors++; $display("FAIL up_floor3 got=%0d exp=3", bus.floor); end
        checks++; if (bus.arrived !== 1'b1) begin errors++; $display("FAIL up_arrived got=%b exp=1", bus.arrived); end
        checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL up_stopped moving got=%b exp=0", bus.moving); end
      end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL up_pulses got=%0d exp=1", pulses); end
    checks++; if (bus.floor !== 3'd3) begin errors++; $display("FAIL up_stays got=%0d exp=3", bus.floor); end
    bus.sw = 8'h00;
  endtask

  task automatic test_door_hold();
    int moved = 0, pulses = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.door = 1'b1; bus.dir = 1'b1; bus.sw = 8'h80;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.moving !== 1'b0) moved++;
      if (bus.arrived !== 1'b0) pulses++;
    end
    checks++; if (bus.floor !== 3'd0) begin errors++; $display("FAIL door_floor got=%0d exp=0", bus.floor); end
    checks++; if (moved != 0) begin errors++; $display("FAIL door_moving cycles got=%0d exp=0", moved); end
    checks++; if (pulses != 0) begin errors++; $display("FAIL door_arrived cycles got=%0d exp=0", pulses); end
    bus.door = 1'b0; bus.sw = 8'h00;
  endtask

  task automatic test_redirect();
    int  cyc = 0;
    bit  ok;
    bus.door = 1'b0; bus.dir = 1'b1; bus.sw = 8'h20;
    while (bus.floor !== 3'd1 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++; if (bus.floor !== 3'd1) begin errors++; $display("FAIL redir_reach1 got=%0d exp=1", bus.floor); end
    bus.sw = 8'h24; bus.dir = 1'b0;
    run_until_arrived(20, cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL redir_timeout cycles=%0d exp_arrival=1", cyc); end
    checks++; if (bus.floor !== 3'd2) begin errors++; $display("FAIL redir_floor got=%0d exp=2", bus.floor); end
    checks++; if (bus.travel_dir !== 1'b1) begin errors++; $display("FAIL redir_tdir got=%b exp=1", bus.travel_dir); end
    bus.sw = 8'h00;
  endtask

  task automatic test_top_boundary();
    int  cyc, moved = 0, pulses = 0;
    bit  ok;
    bus.door = 1'b0; bus.dir = 1'b1; bus.sw = 8'h80;
    run_until_arrived(40, cyc, ok);
    checks++; if (!ok || bus.floor !== 3'd7) begin errors++; $display("FAIL top_reach got=%0d ok=%0d exp=7", bus.floor, ok); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.moving !== 1'b0) moved++;
    end
    checks++; if (moved != 0 || bus.floor !== 3'd7) begin errors++; $display("FAIL top_hold moving=%0d floor=%0d exp=0,7", moved, bus.floor); end
    bus.dir = 1'b0; bus.sw = 8'h01; moved = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.moving === 1'b1) moved++;
      if (bus.arrived === 1'b1) pulses++;
    end
    checks++; if (bus.floor !== 3'd0) begin errors++; $display("FAIL down_floor got=%0d exp=0", bus.floor); end
    checks++; if (moved != 7 * TC) begin errors++; $display("FAIL down_travel_clocks got=%0d exp=%0d", moved, 7 * TC); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL down_pulses got=%0d exp=1", pulses); end
    bus.sw = 8'h00;
  endtask

  task automatic test_reset_mid_travel();
    int cyc;
    bit ok;
    bus.door = 1'b0; bus.dir = 1'b1; bus.sw = 8'h08;
    run_until_arrived(30, cyc, ok);
    checks++; if (!ok || bus.floor !== 3'd3) begin errors++; $display("FAIL mid_setup floor=%0d ok=%0d exp=3", bus.floor, ok); end
    @(negedge clk);
    bus.sw = 8'h10;
    repeat (3) @(negedge clk);
    checks++; if (bus.moving !== 1'b1) begin errors++; $display("FAIL mid_moving got=%b exp=1", bus.moving); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.sw = 8'h00;
    checks++; if (bus.floor !== 3'd0) begin errors++; $display("FAIL mid_rst_floor got=%0d exp=0", bus.floor); end
    checks++; if (bus.moving !== 1'b0) begin errors++; $display("FAIL mid_rst_moving got=%b exp=0", bus.moving); end
    checks++; if (bus.arrived !== 1'b0) begin errors++; $display("FAIL mid_rst_arrived got=%b exp=0", bus.arrived); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      checks++; if (bus.floor !== 3'(m_floor)) begin errors++; $display("FAIL rnd_floor cyc=%0d got=%0d exp=%0d", k, bus.floor, m_floor); end
      checks++; if (bus.moving !== m_moving) begin errors++; $display("FAIL rnd_moving cyc=%0d got=%b exp=%b", k, bus.moving, m_moving); end
      checks++; if (bus.travel_dir !== m_dir) begin errors++; $display("FAIL rnd_tdir cyc=%0d got=%b exp=%b", k, bus.travel_dir, m_dir); end
      checks++; if (bus.arrived !== m_arr) begin errors++; $display("FAIL rnd_arrived cyc=%0d got=%b exp=%b", k, bus.arrived, m_arr); end
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 19) == 0) bus.sw = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bus.door = ~bus.door;
      if ($urandom_range(0, 3) == 0) bus.dir = 1'($urandom);
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.sw = 8'h00; bus.dir = 1'b1; bus.door = 1'b0;
    test_reset();
    test_up_trip();
    test_door_hold();
    test_redirect();
    test_top_boundary();
    test_reset_mid_travel();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
